uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter and its external baud-tick generator. Integrates the baud divider, a TX FIFO with valid/ready push handshake, runtime-selectable data width (5..MAX_BITS), parity (none/even/odd) and 1 or 2 stop bits. Sits between the crypto core's output stream and the board UART pin, and sends queued bytes back-to-back without CPU pacing.

Parameters:
MAX_BITS, 9, widest data field supported; legal range 5..9
FIFO_DEPTH, 8, TX FIFO entries; power of 2, >=2
DIV_W, 9, width of baud divisor (54 gives 115200 baud x16 at 100 MHz)
OVERSAMPLE, 16, baud ticks per bit period

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
baud_div  in  DIV_W  clocks per baud tick; 0 treated as 1
n_bits  in  4  data bits per frame; clamped to 5..MAX_BITS
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
two_stop  in  1  1 = two stop bits
tx_data  in  MAX_BITS  word to queue; only n_bits LSBs sent
tx_valid  in  1  push request
tx_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
tx_out  out  1  serial line, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of each frame
fifo_count  out  clog2(FIFO_DEPTH)+1  entries queued

Behaviour:
- Reset (reset=0, async): tx_out=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_count=0, FIFO pointers 0, baud counter 0, state IDLE. Reset mid-frame aborts the frame; tx_out goes high immediately; queued data is discarded.
- Baud divider: free-running counter 0..baud_div-1; tick asserted for one clock when counter == baud_div-1. A baud_div change takes effect at the next wrap.
- Bit timing: sub-counter counts ticks 0..OVERSAMPLE-1. A bit ends on the tick where the sub-counter == OVERSAMPLE-1.
- FIFO push: a word is written when tx_valid && tx_ready. tx_ready is registered-count based only, with no combinational path from the pop.
- FIFO, no bypass: a word pushed into an empty FIFO is visible at the next cycle.
- FIFO, full: push and pop in the same cycle is only possible when not full. Count then stays unchanged.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: on a tick with fifo_count>0. In that cycle: pop the head word; latch the word, clamped n_bits, parity_mode and two_stop; sub-counter=0. tx_out=0 is registered on the same edge.
- START -> DATA after 1 bit period.
- DATA: data bits are sent LSB first. After n_bits bit periods, go to PARITY if parity is enabled, else STOP.
- PARITY: parity is computed over the n_bits LSBs only. Even parity makes the total count of ones even; odd parity makes it odd. Lasts 1 bit period.
- STOP: tx_out=1 for 1 bit period, or 2 if two_stop=1.
- End of STOP:
  - tx_done=1 for exactly that one cycle.
  - If fifo_count>0, go straight to START: pop and latch config, with no idle gap.
  - Otherwise go to IDLE.
- tx_busy=1 in every state except IDLE. It stays high across back-to-back frames.
- Config inputs changing mid-frame do not affect the current frame.
- Frame length = (1 + n + p + s) * OVERSAMPLE * max(baud_div,1) clocks, where p is 0 or 1 and s is 1 or 2.
- tx_out is registered, so it is glitch-free.

Test Plan:
- Reset: hold reset=0 with tx_valid=1 -> tx_out=1, tx_ready=1, fifo_count=0, no push accepted. Release reset -> push accepted next edge.
- 8N1 with baud_div=4, push 0x75 -> line is 0,1,0,1,0,1,1,1,0,1 (start, LSB-first data, stop). Each bit is 64 clocks; frame is 640 clocks; tx_done pulses once at the frame end; tx_busy=0 afterwards.
- 7E1: n_bits=7, parity_mode=01, push 0x52 -> data 0,1,0,0,1,0,1, then parity bit 1, then stop. 8O2: parity_mode=10, two_stop=1, push 0x75 -> parity bit 0, stop high for 32 ticks.
- Overflow and back-to-back: baud_div=54, push 10 words on consecutive cycles with tx_valid held.
  - tx_ready drops when fifo_count reaches 8.
  - Exactly FIFO_DEPTH+1 words are accepted, counting the one popped on the first tick.
  - Each START begins on the cycle after the preceding STOP ends, with no idle bits.
  - tx_done pulses once per word.
- Clamp: n_bits=12 -> 9 data bits sent (MAX_BITS). n_bits=2 -> 5 data bits sent. baud_div=0 -> tick every clock, frame 160 clocks for 8N1.
- Mid-frame reset: assert reset during the DATA state with 3 words queued -> tx_out=1 asynchronously, fifo_count=0, no tx_done. After release, the line stays idle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with an integrated baud divider
// and a TX FIFO. Frames are start + n data bits (LSB first) + optional parity
// + one or two stop bits; queued words are sent back-to-back.
module uart_tx_fifo #(
  parameter int MAX_BITS   = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 9,
  parameter int OVERSAMPLE = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [3:0]                  n_bits,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic [MAX_BITS-1:0]         tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUB_W = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       MINB_C   = 4'd5;
  localparam logic [3:0]       MAXB_C   = 4'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Clamp the requested data width into the supported 5..MAX_BITS range.
  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    logic [3:0] r;
    if (n < MINB_C) begin
      r = MINB_C;
    end else if (n > MAXB_C) begin
      r = MAXB_C;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // Parity over the n least-significant bits; odd=1 seeds the XOR with one.
  function automatic logic calc_parity(input logic [MAX_BITS-1:0] d,
                                       input logic [3:0]          n,
                                       input logic                odd);
    logic acc;
    acc = odd;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (4'(i) < n) begin
        acc = acc ^ d[i];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Registered state
  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]      div_lat_q, div_lat_d;
  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [3:0]            bit_q, bit_d;
  logic [MAX_BITS-1:0]   shift_q, shift_d;
  logic [3:0]            n_q, n_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_q, two_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [MAX_BITS-1:0]   mem_q [FIFO_DEPTH];

  // Combinational helpers
  logic [DIV_W-1:0]      div_eff_s;
  logic                  tick_s;
  logic                  bit_end_s;
  logic                  has_data_s;
  logic                  load_s;
  logic                  pop_s;
  logic                  push_s;
  logic [MAX_BITS-1:0]   head_s;

  // Baud divider: counter wraps at the latched divisor, a new divisor is sampled on each wrap.
  always_comb begin
    if (div_lat_q == '0) begin
      div_eff_s = DIV_W'(1);
    end else begin
      div_eff_s = div_lat_q;
    end
    tick_s = (div_cnt_q == (div_eff_s - DIV_W'(1)));
    if (tick_s) begin
      div_cnt_d = '0;
      div_lat_d = baud_div;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      div_lat_d = div_lat_q;
    end
  end

  assign bit_end_s  = tick_s && (sub_q == SUB_LAST);
  assign has_data_s = (cnt_q != '0);
  assign head_s     = mem_q[rd_ptr_q];

  // Frame sequencer: next state, next line level and frame-config latching.
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    n_d       = n_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    two_d     = two_q;
    stop_d    = stop_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    load_s    = 1'b0;
    pop_s     = 1'b0;

    if (tick_s && (state_q != S_IDLE)) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end else begin
      sub_d = sub_q;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tick_s && has_data_s) begin
          load_s  = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          bit_d   = 4'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          if (bit_q == (n_q - 4'd1)) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (two_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (has_data_s) begin
              load_s  = 1'b1;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Starting a frame pops the head word and freezes the frame config.
    if (load_s) begin
      pop_s     = 1'b1;
      shift_d   = head_s;
      n_d       = clamp_bits(n_bits);
      par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d = calc_parity(head_s, clamp_bits(n_bits), parity_mode == 2'b10);
      two_d     = two_stop;
      sub_d     = '0;
      bit_d     = 4'd0;
      stop_d    = 1'b0;
    end else begin
      pop_s     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // FIFO bookkeeping: pointers, occupancy and the registered ready flag.
  always_comb begin
    push_s = tx_valid && ready_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d < DEPTH_C);
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // State register with asynchronous active-low reset; reset forces the line idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      div_lat_q <= '0;
      sub_q     <= '0;
      bit_q     <= 4'd0;
      shift_q   <= '0;
      n_q       <= MINB_C;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      two_q     <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_lat_q <= div_lat_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      n_q       <= n_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      two_q     <= two_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign tx_out     = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_ready   = ready_q;
  assign fifo_count = cnt_q;

endmodule
